// File: rtl/ex_stage_pkg.sv
// Shared widths, pipeline control encodings, decode constants and the
// ID/EX register layout for the execute stage.
package ex_stage_pkg;

    localparam int ID_TO_EX_WD  = 159;
    localparam int EX_TO_MEM_WD = 76;
    localparam int STALLBUS_WD  = 6;
    localparam int DIV_CYCLES   = 32;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam logic [5:0] FUNC_DIV  = 6'b011010;
    localparam logic [5:0] FUNC_DIVU = 6'b011011;
    localparam logic [5:0] FUNC_MFHI = 6'b010000;
    localparam logic [5:0] FUNC_MFLO = 6'b010010;
    localparam logic [5:0] FUNC_MTHI = 6'b010001;
    localparam logic [5:0] FUNC_MTLO = 6'b010011;

    // alu_op is one-hot with add in the MSB and lui in bit 0
    localparam int ALU_ADD  = 11;
    localparam int ALU_SUB  = 10;
    localparam int ALU_SLT  = 9;
    localparam int ALU_SLTU = 8;
    localparam int ALU_AND  = 7;
    localparam int ALU_NOR  = 6;
    localparam int ALU_OR   = 5;
    localparam int ALU_XOR  = 4;
    localparam int ALU_SLL  = 3;
    localparam int ALU_SRL  = 2;
    localparam int ALU_SRA  = 1;
    localparam int ALU_LUI  = 0;

    typedef enum logic [1:0] {
        DIV_IDLE,
        DIV_BUSY,
        DIV_DONE
    } div_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [11:0] alu_op;
        logic [2:0]  src1;
        logic [3:0]  src2;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic        sel_rf_res;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
    } id_ex_t;

    function automatic logic [31:0] negate_if(input logic [31:0] value, input logic neg);
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider: one quotient bit per cycle on magnitudes,
// with the sign correction applied to the held result.
module div_unit
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    input  logic        ack,
    output logic [31:0] q,
    output logic [31:0] r
);

    div_state_e  state;
    logic [4:0]  cnt;
    logic [31:0] divisor;
    logic [31:0] quo;
    logic [31:0] rem;
    logic        neg_q;
    logic        neg_r;
    logic [32:0] trial;
    logic        fits;

    // The dividend is shifted out of quo's MSB into the partial remainder
    assign trial = {rem, quo[31]};
    assign fits  = (trial >= {1'b0, divisor});

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= DIV_IDLE;
            cnt     <= '0;
            divisor <= '0;
            quo     <= '0;
            rem     <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        quo     <= negate_if(a, signed_op & a[31]);
                        divisor <= negate_if(b, signed_op & b[31]);
                        rem     <= '0;
                        cnt     <= '0;
                        neg_q   <= signed_op & (a[31] ^ b[31]);
                        neg_r   <= signed_op & a[31];
                        state   <= DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    if (fits) begin
                        rem <= trial[31:0] - divisor;
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= trial[31:0];
                        quo <= {quo[30:0], 1'b0};
                    end
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(DIV_CYCLES - 1)) begin
                        state <= DIV_DONE;
                    end
                end
                DIV_DONE: begin
                    if (ack) begin
                        state <= DIV_IDLE;
                    end
                end
                default: state <= DIV_IDLE;
            endcase
        end
    end

    assign busy = (state == DIV_BUSY);
    assign done = (state == DIV_DONE);
    assign q    = negate_if(quo, neg_q);
    assign r    = negate_if(rem, neg_r);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register, inline ALU, data-SRAM request,
// HI/LO registers and the multi-cycle divider.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALLBUS_WD-1:0]  stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata,
    output logic                    stallreq_for_ex
);

    id_ex_t      ex;
    logic        ex_release;
    logic        is_special;
    logic [5:0]  func;
    logic        is_div;
    logic        is_divu;
    logic        is_div_op;
    logic        is_mfhi;
    logic        is_mflo;
    logic        is_mthi;
    logic        is_mtlo;
    logic        is_store;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] alu_res;
    logic [31:0] ex_result;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic        rf_we_out;
    logic [4:0]  rf_waddr_out;
    logic        unused_ok;

    assign ex_release = (stall[2] == NO_STOP);

    // A stalled ID feeding a running EX/MEM inserts a bubble rather than a duplicate
    always_ff @(posedge clk) begin
        if (!rst) begin
            ex <= '0;
        end else if (stall[2] == STOP && stall[3] == NO_STOP) begin
            ex <= '0;
        end else if (stall[2] == NO_STOP) begin
            ex <= id_ex_t'(id_to_ex_bus);
        end
    end

    assign func       = ex.inst[5:0];
    assign is_special = (ex.inst[31:26] == 6'b000000);
    assign is_div     = is_special && (func == FUNC_DIV);
    assign is_divu    = is_special && (func == FUNC_DIVU);
    assign is_div_op  = is_div | is_divu;
    assign is_mfhi    = is_special && (func == FUNC_MFHI);
    assign is_mflo    = is_special && (func == FUNC_MFLO);
    assign is_mthi    = is_special && (func == FUNC_MTHI);
    assign is_mtlo    = is_special && (func == FUNC_MTLO);
    assign is_store   = ex.ram_en & (|ex.ram_wen);

    assign src1 = ({32{ex.src1[0]}} & ex.rs_data)
                | ({32{ex.src1[1]}} & ex.pc)
                | ({32{ex.src1[2]}} & {27'b0, ex.inst[10:6]});

    assign src2 = ({32{ex.src2[0]}} & ex.rt_data)
                | ({32{ex.src2[1]}} & {{16{ex.inst[15]}}, ex.inst[15:0]})
                | ({32{ex.src2[2]}} & 32'd8)
                | ({32{ex.src2[3]}} & {16'b0, ex.inst[15:0]});

    always_comb begin
        alu_res = '0;
        if (ex.alu_op[ALU_ADD])  alu_res = alu_res | (src1 + src2);
        if (ex.alu_op[ALU_SUB])  alu_res = alu_res | (src1 - src2);
        if (ex.alu_op[ALU_SLT])  alu_res = alu_res | {31'b0, $signed(src1) < $signed(src2)};
        if (ex.alu_op[ALU_SLTU]) alu_res = alu_res | {31'b0, src1 < src2};
        if (ex.alu_op[ALU_AND])  alu_res = alu_res | (src1 & src2);
        if (ex.alu_op[ALU_NOR])  alu_res = alu_res | ~(src1 | src2);
        if (ex.alu_op[ALU_OR])   alu_res = alu_res | (src1 | src2);
        if (ex.alu_op[ALU_XOR])  alu_res = alu_res | (src1 ^ src2);
        if (ex.alu_op[ALU_SLL])  alu_res = alu_res | (src2 << src1[4:0]);
        if (ex.alu_op[ALU_SRL])  alu_res = alu_res | (src2 >> src1[4:0]);
        if (ex.alu_op[ALU_SRA])  alu_res = alu_res | $unsigned($signed(src2) >>> src1[4:0]);
        if (ex.alu_op[ALU_LUI])  alu_res = alu_res | {src2[15:0], 16'b0};
    end

    div_unit u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div_op),
        .signed_op (is_div),
        .a         (ex.rs_data),
        .b         (ex.rt_data),
        .busy      (div_busy),
        .done      (div_done),
        .ack       (ex_release),
        .q         (div_q),
        .r         (div_r)
    );

    // The IDLE cycle of a fresh divide must already stall, before the FSM moves
    assign stallreq_for_ex = div_busy | (is_div_op & ~div_busy & ~div_done);

    // Writes only as the instruction leaves EX, so a held instruction writes once
    always_ff @(posedge clk) begin
        if (!rst) begin
            hi <= '0;
            lo <= '0;
        end else if (ex_release) begin
            if (is_div_op && div_done) begin
                lo <= div_q;
                hi <= div_r;
            end else if (is_mthi) begin
                hi <= ex.rs_data;
            end else if (is_mtlo) begin
                lo <= ex.rs_data;
            end
        end
    end

    assign ex_result    = is_mfhi ? hi : (is_mflo ? lo : alu_res);
    assign rf_we_out    = (is_mfhi | is_mflo) ? 1'b1
                        : (is_div_op | is_mthi | is_mtlo | is_store) ? 1'b0
                        : ex.rf_we;
    assign rf_waddr_out = (is_mfhi | is_mflo) ? ex.inst[15:11] : ex.rf_waddr;

    assign ex_to_mem_bus = {ex.pc, ex.ram_en, ex.ram_wen, ex.sel_rf_res,
                            rf_we_out, rf_waddr_out, ex_result};

    assign data_sram_en    = ex.ram_en & ~stallreq_for_ex;
    assign data_sram_wen   = ex.ram_wen & {4{~stallreq_for_ex}};
    assign data_sram_addr  = stallreq_for_ex ? 32'd0 : alu_res;
    assign data_sram_wdata = stallreq_for_ex ? 32'd0 : ex.rt_data;

    assign unused_ok = ^{stall[5:4], stall[1:0], ex.inst[25:16]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: stimulus pushes expected EX outputs into a
// queue that a monitor drains as each instruction leaves EX.
module tb_ex_stage;
    import ex_stage_pkg::*;

    typedef struct packed {
        logic [7:0]  id;
        logic [75:0] bus;
        logic [68:0] sram;
        logic [7:0]  stalls;
    } exp_t;

    localparam logic [11:0] OP_ADD  = 12'h800;
    localparam logic [2:0]  S1_RS   = 3'b001;
    localparam logic [3:0]  S2_SEXT = 4'b0010;

    logic                    clk = 1'b0;
    logic                    rst = 1'b0;
    logic                    force_bubble = 1'b0;
    logic [STALLBUS_WD-1:0]  stall;
    logic [ID_TO_EX_WD-1:0]  id_to_ex_bus = '0;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic                    data_sram_en;
    logic [3:0]              data_sram_wen;
    logic [31:0]             data_sram_addr;
    logic [31:0]             data_sram_wdata;
    logic                    stallreq_for_ex;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    assign stall = force_bubble    ? 6'b000111 :
                   stallreq_for_ex ? 6'b001111 : 6'b000000;

    ex_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .id_to_ex_bus    (id_to_ex_bus),
        .ex_to_mem_bus   (ex_to_mem_bus),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .stallreq_for_ex (stallreq_for_ex)
    );

    function automatic logic [158:0] mk_id(
        input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] alu_op,
        input logic [2:0] src1, input logic [3:0] src2, input logic ram_en,
        input logic [3:0] ram_wen, input logic rf_we, input logic [4:0] waddr,
        input logic sel, input logic [31:0] rs, input logic [31:0] rt);
        return {pc, inst, alu_op, src1, src2, ram_en, ram_wen, rf_we, waddr, sel, rs, rt};
    endfunction

    function automatic exp_t mk_exp(
        input logic [7:0] id, input logic [31:0] pc, input logic ram_en,
        input logic [3:0] ram_wen, input logic rf_we, input logic [4:0] waddr,
        input logic [31:0] result, input logic [31:0] addr, input logic [31:0] wdata,
        input logic [7:0] stalls);
        exp_t e;
        e.id     = id;
        e.bus    = {pc, ram_en, ram_wen, 1'b0, rf_we, waddr, result};
        e.sram   = {ram_en, ram_wen, addr, wdata};
        e.stalls = stalls;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [158:0] bus, input exp_t e, input bit has_exp);
        int waited;
        waited = 0;
        @(negedge clk);
        while (stall[2] !== 1'b0 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL issue timeout: stall[2]=%b expected 0", stall[2]);
        end
        id_to_ex_bus = bus;
        if (has_exp) exp_q.push_back(e);
        @(posedge clk);
        #1 id_to_ex_bus = '0;
    endtask

    // Monitor: an instruction presents its result when it sits in EX unstalled
    initial begin : monitor
        int   stall_run;
        exp_t e;
        stall_run = 0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                stall_run = 0;
            end else if (stallreq_for_ex === 1'b1) begin
                stall_run++;
            end else if (ex_to_mem_bus[75:44] != 32'd0) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected output pc", ex_to_mem_bus[75:44], 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput($sformatf("instr%0d bus", e.id), ex_to_mem_bus, e.bus);
                    checkOutput($sformatf("instr%0d sram", e.id),
                                {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
                                e.sram);
                    checkOutput($sformatf("instr%0d stall cycles", e.id), stall_run, e.stalls);
                end
                stall_run = 0;
            end else begin
                stall_run = 0;
            end
        end
    end

    initial begin : stimulus
        exp_t none;
        int   drain;
        none = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset bus", ex_to_mem_bus, '0);
        checkOutput("reset stallreq", stallreq_for_ex, 1'b0);
        rst = 1'b1;

        // addiu r2, r1, -1 with r1=5
        applyStimulus(mk_id(32'hBFC00000, 32'h2422FFFF, OP_ADD, S1_RS, S2_SEXT, 1'b0, 4'h0,
                            1'b1, 5'd2, 1'b0, 32'd5, 32'd0),
                      mk_exp(8'd1, 32'hBFC00000, 1'b0, 4'h0, 1'b1, 5'd2, 32'd4,
                             32'd4, 32'd0, 8'd0), 1'b1);
        // sw: ID marks rf_we, EX must drop it
        applyStimulus(mk_id(32'hBFC00004, 32'hAC640008, OP_ADD, S1_RS, S2_SEXT, 1'b1, 4'hF,
                            1'b1, 5'd4, 1'b0, 32'h1000, 32'hDEADBEEF),
                      mk_exp(8'd2, 32'hBFC00004, 1'b1, 4'hF, 1'b0, 5'd4, 32'h1008,
                             32'h1008, 32'hDEADBEEF, 8'd0), 1'b1);
        // div -7 / 2
        applyStimulus(mk_id(32'hBFC00008, 32'h00A6001A, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                            1'b0, 5'd0, 1'b0, 32'hFFFFFFF9, 32'd2),
                      mk_exp(8'd3, 32'hBFC00008, 1'b0, 4'h0, 1'b0, 5'd0, 32'd0,
                             32'd0, 32'd2, 8'd33), 1'b1);
        @(negedge clk);
        checkOutput("sram masked during div",
                    {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, '0);
        // mflo rd=8, mfhi rd=9: ID leaves rf_we clear, EX forces it
        applyStimulus(mk_id(32'hBFC0000C, 32'h00004012, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                            1'b0, 5'd0, 1'b0, 32'd0, 32'd0),
                      mk_exp(8'd4, 32'hBFC0000C, 1'b0, 4'h0, 1'b1, 5'd8, 32'hFFFFFFFD,
                             32'd0, 32'd0, 8'd0), 1'b1);
        applyStimulus(mk_id(32'hBFC00010, 32'h00004810, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                            1'b0, 5'd0, 1'b0, 32'd0, 32'd0),
                      mk_exp(8'd5, 32'hBFC00010, 1'b0, 4'h0, 1'b1, 5'd9, 32'hFFFFFFFF,
                             32'd0, 32'd0, 8'd0), 1'b1);
        // divu 10 / 0
        applyStimulus(mk_id(32'hBFC00014, 32'h00A6001B, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                            1'b0, 5'd0, 1'b0, 32'd10, 32'd0),
                      mk_exp(8'd6, 32'hBFC00014, 1'b0, 4'h0, 1'b0, 5'd0, 32'd0,
                             32'd0, 32'd0, 8'd33), 1'b1);
        applyStimulus(mk_id(32'hBFC00018, 32'h00004810, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                            1'b0, 5'd0, 1'b0, 32'd0, 32'd0),
                      mk_exp(8'd7, 32'hBFC00018, 1'b0, 4'h0, 1'b1, 5'd9, 32'd10,
                             32'd0, 32'd0, 8'd0), 1'b1);
        applyStimulus(mk_id(32'hBFC0001C, 32'h00004012, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                            1'b0, 5'd0, 1'b0, 32'd0, 32'd0),
                      mk_exp(8'd8, 32'hBFC0001C, 1'b0, 4'h0, 1'b1, 5'd8, 32'hFFFFFFFF,
                             32'd0, 32'd0, 8'd0), 1'b1);

        // div 100 / 3 aborted by reset partway through BUSY
        applyStimulus(mk_id(32'hBFC00020, 32'h00A6001A, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                            1'b0, 5'd0, 1'b0, 32'd100, 32'd3), none, 1'b0);
        repeat (11) @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("abort stallreq", stallreq_for_ex, 1'b0);
        checkOutput("abort bus", ex_to_mem_bus, '0);
        applyStimulus(mk_id(32'hBFC00024, 32'h00004810, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                            1'b0, 5'd0, 1'b0, 32'd0, 32'd0),
                      mk_exp(8'd9, 32'hBFC00024, 1'b0, 4'h0, 1'b1, 5'd9, 32'd0,
                             32'd0, 32'd0, 8'd0), 1'b1);
        applyStimulus(mk_id(32'hBFC00028, 32'h00004012, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                            1'b0, 5'd0, 1'b0, 32'd0, 32'd0),
                      mk_exp(8'd10, 32'hBFC00028, 1'b0, 4'h0, 1'b1, 5'd8, 32'd0,
                             32'd0, 32'd0, 8'd0), 1'b1);

        // mtlo 0x11, then an mtlo 0x77 squashed into a bubble, then mflo
        applyStimulus(mk_id(32'hBFC0002C, 32'h00E00013, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                            1'b1, 5'd0, 1'b0, 32'h11, 32'd0),
                      mk_exp(8'd11, 32'hBFC0002C, 1'b0, 4'h0, 1'b0, 5'd0, 32'd0,
                             32'd0, 32'd0, 8'd0), 1'b1);
        applyStimulus(mk_id(32'hBFC00030, 32'h00E00013, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                            1'b0, 5'd0, 1'b0, 32'h77, 32'd0),
                      mk_exp(8'd12, 32'hBFC00030, 1'b0, 4'h0, 1'b0, 5'd0, 32'd0,
                             32'd0, 32'd0, 8'd0), 1'b1);
        @(negedge clk);
        force_bubble = 1'b1;
        @(posedge clk);
        #1 force_bubble = 1'b0;
        @(negedge clk);
        checkOutput("bubble bus", ex_to_mem_bus, '0);
        applyStimulus(mk_id(32'hBFC00034, 32'h00004012, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                            1'b0, 5'd0, 1'b0, 32'd0, 32'd0),
                      mk_exp(8'd13, 32'hBFC00034, 1'b0, 4'h0, 1'b1, 5'd8, 32'h11,
                             32'd0, 32'd0, 8'd0), 1'b1);
        applyStimulus(mk_id(32'hBFC00038, 32'h00E00013, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                            1'b0, 5'd0, 1'b0, 32'h55, 32'd0),
                      mk_exp(8'd14, 32'hBFC00038, 1'b0, 4'h0, 1'b0, 5'd0, 32'd0,
                             32'd0, 32'd0, 8'd0), 1'b1);
        applyStimulus(mk_id(32'hBFC0003C, 32'h00004012, 12'h000, 3'b000, 4'b0000, 1'b0, 4'h0,
                            1'b0, 5'd0, 1'b0, 32'd0, 32'd0),
                      mk_exp(8'd15, 32'hBFC0003C, 1'b0, 4'h0, 1'b1, 5'd8, 32'h55,
                             32'd0, 32'd0, 8'd0), 1'b1);

        drain = 0;
        while (exp_q.size() != 0 && drain < 100) begin
            @(negedge clk);
            drain++;
        end
        @(negedge clk);
        checkOutput("outputs outstanding", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
